// File: rtl/pipeline_sink_pkg.sv
// Purpose: shared types and default sizing for the pipeline frame sink.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_sink_pkg;

    localparam int DATA_W        = 32;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_FRAME_LEN = 4;

    // DATA drains queued words, CSUM presents the closing checksum word.
    typedef enum logic {
        ST_DATA = 1'b0,
        ST_CSUM = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_sink_fifo.sv
// Purpose: synchronous show-ahead FIFO with clear, head word always visible.
// Latency: a word pushed in cycle N is on o_head in cycle N+1.
// Backpressure: pushes while full and pops while empty are ignored; clear wins.
module pipeline_sink_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push & ~o_full  & ~i_clear;
    assign w_pop   = i_pop  & ~o_empty & ~i_clear;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pipeline_frame_sink.sv
// Purpose: drains queued upstream words as frames of FRAME_LEN words plus a checksum word.
// Latency: pushed word visible on m_data the next cycle; checksum follows the last data word.
// Backpressure: stall_o is the registered FIFO-full flag; m_ready stalls the drain side.
module pipeline_frame_sink
    import pipeline_sink_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_flush,
    output logic              stall_o,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              flush_done,
    output logic [CNT_W-1:0]  frame_count
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_csum;
    logic [15:0]         r_word_idx;
    logic [CNT_W-1:0]    r_frame_count;
    logic                r_flush_done;

    logic [DATA_W-1:0]   w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_csum_hs;
    logic                w_m_valid;
    logic                w_m_last;
    logic [DATA_W-1:0]   w_m_data;

    // Upstream word is taken only when there is room and no flush is discarding it.
    assign w_push = in_valid & ~w_full & ~in_flush;

    pipeline_sink_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (in_flush),
        .i_data  (in_data),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Next-state and drain-port decode; flush masks m_valid and forces a return to DATA.
    always_comb begin
        w_next_state = r_state;
        w_m_valid    = 1'b0;
        w_m_last     = 1'b0;
        w_m_data     = '0;
        w_pop        = 1'b0;
        w_csum_hs    = 1'b0;
        case (r_state)
            ST_DATA: begin
                w_m_valid = ~w_empty & ~in_flush;
                w_m_data  = w_empty ? '0 : w_head;
                w_pop     = w_m_valid & m_ready;
                if (w_pop && (r_word_idx == LAST_IDX)) w_next_state = ST_CSUM;
            end
            ST_CSUM: begin
                w_m_valid = ~in_flush;
                w_m_data  = r_csum;
                w_m_last  = 1'b1;
                w_csum_hs = w_m_valid & m_ready;
                if (w_csum_hs) w_next_state = ST_DATA;
            end
            default: w_next_state = ST_DATA;
        endcase
        if (in_flush) w_next_state = ST_DATA;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_DATA;
        else       r_state <= w_next_state;
    end

    // Checksum, word index and frame counter; a flush drops the partial frame but keeps the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum        <= '0;
            r_word_idx    <= '0;
            r_frame_count <= '0;
        end else if (in_flush) begin
            r_csum     <= '0;
            r_word_idx <= '0;
        end else if (w_pop) begin
            r_csum     <= r_csum + w_head;
            r_word_idx <= r_word_idx + 1'b1;
        end else if (w_csum_hs) begin
            r_csum        <= '0;
            r_word_idx    <= '0;
            r_frame_count <= r_frame_count + 1'b1;
        end
    end

    // One-cycle acknowledge following each sampled flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_flush_done <= 1'b0;
        else       r_flush_done <= in_flush;
    end

    assign stall_o     = w_full;
    assign m_valid     = w_m_valid;
    assign m_last      = w_m_last;
    assign m_data      = w_m_data;
    assign flush_done  = r_flush_done;
    assign frame_count = r_frame_count;

endmodule
